// File: rtl/led_blinker.sv
// Four-LED pattern sequencer: prescaled step tick walks through five
// fixed patterns (counter, knight rider, fill, pairs, blink) forever.
module led_blinker #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BLINK_FREQ = 2
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    output logic [3:0] led
);

    localparam int DIV = CLK_FREQ / BLINK_FREQ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    typedef enum logic [2:0] {
        P_BIN    = 3'd0,
        P_KNIGHT = 3'd1,
        P_FILL   = 3'd2,
        P_PAIRS  = 3'd3,
        P_BLINK  = 3'd4
    } pat_e;

    logic [CW-1:0] prescaler;
    logic          tick;
    pat_e          pattern_state;
    pat_e          next_state;
    logic [3:0]    step;
    logic [3:0]    next_step;
    logic [3:0]    next_led;

    function automatic logic [3:0] last_step(input pat_e ps);
        case (ps)
            P_BIN:    last_step = 4'd15;
            P_KNIGHT: last_step = 4'd5;
            P_FILL:   last_step = 4'd7;
            P_PAIRS:  last_step = 4'd7;
            P_BLINK:  last_step = 4'd7;
            default:  last_step = 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] decode(input pat_e ps, input logic [3:0] st);
        decode = 4'b0000;
        case (ps)
            P_BIN: decode = st;
            P_KNIGHT: begin
                case (st)
                    4'd0:    decode = 4'b0001;
                    4'd1:    decode = 4'b0010;
                    4'd2:    decode = 4'b0100;
                    4'd3:    decode = 4'b1000;
                    4'd4:    decode = 4'b0100;
                    4'd5:    decode = 4'b0010;
                    default: decode = 4'b0000;
                endcase
            end
            P_FILL: begin
                case (st)
                    4'd0:    decode = 4'b0001;
                    4'd1:    decode = 4'b0011;
                    4'd2:    decode = 4'b0111;
                    4'd3:    decode = 4'b1111;
                    4'd4:    decode = 4'b0111;
                    4'd5:    decode = 4'b0011;
                    4'd6:    decode = 4'b0001;
                    default: decode = 4'b0000;
                endcase
            end
            P_PAIRS: decode = st[0] ? 4'b1100 : 4'b0011;
            P_BLINK: decode = st[0] ? 4'b0000 : 4'b1111;
            default: decode = 4'b0000;
        endcase
    endfunction

    assign tick = (prescaler == LAST);

    always_comb begin
        next_state = pattern_state;
        next_step  = step;
        if (tick) begin
            if (step < last_step(pattern_state)) begin
                next_step = step + 4'd1;
            end else begin
                next_step = 4'd0;
                case (pattern_state)
                    P_BIN:    next_state = P_KNIGHT;
                    P_KNIGHT: next_state = P_FILL;
                    P_FILL:   next_state = P_PAIRS;
                    P_PAIRS:  next_state = P_BLINK;
                    default:  next_state = P_BIN;
                endcase
            end
        end
        // led is loaded with the decode of the next state so it never lags
        next_led = decode(next_state, next_step);
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            prescaler     <= '0;
            pattern_state <= P_BIN;
            step          <= 4'd0;
            led           <= 4'b0000;
        end else begin
            prescaler     <= tick ? '0 : prescaler + CW'(1);
            pattern_state <= next_state;
            step          <= next_step;
            led           <= next_led;
        end
    end

endmodule

// File: tb/tb_led_blinker.sv
// Scoreboard bench: small-divider instance walks the full sequence,
// fast-rate instance checks timing at a realistic divider.
module tb_led_blinker;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic [3:0] led_a;
    logic [3:0] led_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_q[$];
    logic [3:0] seq[46];
    logic [3:0] kr[6]   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};
    logic [3:0] fill[8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                            4'b0111, 4'b0011, 4'b0001, 4'b0000};

    always #5 clk = ~clk;

    led_blinker #(.CLK_FREQ(8), .BLINK_FREQ(1)) dut_a (
        .clk_50mhz(clk),
        .rst      (rst_a),
        .led      (led_a)
    );

    led_blinker #(.CLK_FREQ(50_000_000), .BLINK_FREQ(2000)) dut_b (
        .clk_50mhz(clk),
        .rst      (rst_b),
        .led      (led_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // One tick period of dut_a: led must hold for 7 edges, then change.
    task automatic run_tick_a(input int k);
        logic [3:0] prev;
        logic [3:0] e;
        prev = led_a;
        repeat (7) begin
            step_clk();
            check($sformatf("hold_t%0d", k), {28'd0, led_a}, {28'd0, prev});
        end
        step_clk();
        if (exp_q.size() == 0) begin
            check($sformatf("q_empty_t%0d", k), 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("led_t%0d", k), {28'd0, led_a}, {28'd0, e});
        end
    endtask

    initial begin
        int changes;
        int first_at;
        logic [3:0] prev;
        logic [3:0] e;

        for (int i = 0; i < 16; i++) seq[i] = 4'(i);
        for (int i = 0; i < 6; i++) seq[16 + i] = kr[i];
        for (int i = 0; i < 8; i++) seq[22 + i] = fill[i];
        for (int i = 0; i < 8; i++) seq[30 + i] = i[0] ? 4'b1100 : 4'b0011;
        for (int i = 0; i < 8; i++) seq[38 + i] = i[0] ? 4'b0000 : 4'b1111;

        repeat (10) step_clk();
        check("rst_led", {28'd0, led_a}, 32'd0);
        check("rst_ps", {29'd0, dut_a.pattern_state}, 32'd0);
        check("rst_led_b", {28'd0, led_b}, 32'd0);

        rst_a = 1'b0;
        for (int k = 1; k <= 46; k++) exp_q.push_back(seq[k % 46]);
        for (int k = 1; k <= 46; k++) begin
            run_tick_a(k);
            if (k == 16)
                check("ps_after16", {29'd0, dut_a.pattern_state}, 32'd1);
            if (k == 22)
                check("ps_after22", {29'd0, dut_a.pattern_state}, 32'd2);
            if (k == 30)
                check("ps_after30", {29'd0, dut_a.pattern_state}, 32'd3);
            if (k == 38)
                check("ps_after38", {29'd0, dut_a.pattern_state}, 32'd4);
        end
        check("ps_wrap", {29'd0, dut_a.pattern_state}, 32'd0);

        for (int k = 47; k <= 78; k++) exp_q.push_back(seq[k % 46]);
        for (int k = 47; k <= 78; k++) run_tick_a(k);
        check("ps_mid", {29'd0, dut_a.pattern_state}, 32'd3);

        rst_a = 1'b1;
        step_clk();
        check("mid_rst_led", {28'd0, led_a}, 32'd0);
        check("mid_rst_ps", {29'd0, dut_a.pattern_state}, 32'd0);
        check("mid_rst_step", {28'd0, dut_a.step}, 32'd0);
        rst_a = 1'b0;
        for (int k = 1; k <= 3; k++) exp_q.push_back(seq[k]);
        for (int k = 1; k <= 3; k++) run_tick_a(100 + k);
        check("q_drained_a", exp_q.size(), 32'd0);

        rst_b = 1'b0;
        for (int k = 1; k <= 4; k++) exp_q.push_back(4'(k));
        changes  = 0;
        first_at = -1;
        prev     = led_b;
        for (int j = 1; j <= 100000; j++) begin
            step_clk();
            if (led_b !== prev) begin
                changes++;
                if (first_at < 0) first_at = j;
                if (exp_q.size() == 0) begin
                    check("b_extra_change", {28'd0, led_b}, {28'd0, prev});
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("b_led_c%0d", changes), {28'd0, led_b},
                          {28'd0, e});
                end
                prev = led_b;
            end
        end
        check("b_first_change", first_at, 32'd25000);
        check("b_changes", changes, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_blinker.md
Name: led_blinker

Overview:
- Free-running LED pattern sequencer for a 4-LED board.
- Divides the 50 MHz system clock down to a step tick at BLINK_FREQ.
- Steps through five fixed patterns in order, then repeats from the first: binary counter, knight rider, fill-and-empty, alternating pairs, all-blink.
- Top-level board block; no handshake, output drives the LED pins directly.

Parameters:
- CLK_FREQ, 50_000_000, input clock frequency in Hz.
- BLINK_FREQ, 2, pattern step rate in Hz (benches raise it, e.g. 2000, to speed up simulation).

Ports:
- clk_50mhz  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- led  output  4  LED drive, bit 0 = rightmost LED, 1 = on.

Behaviour:
- DIV = CLK_FREQ / BLINK_FREQ, integer division. DIV >= 2 is required.
- Prescaler counter width = $clog2(DIV). It counts 0..DIV-1 and wraps to 0.
- tick is asserted for one cycle when the counter equals DIV-1. One tick therefore occurs every DIV cycles.
- Internal registers:
  - pattern_state, 3 bits, values 0..4. This exact name is visible hierarchically to benches.
  - step, 4 bits.
- Pattern sequences (led values per step; length in brackets):
  - 0 binary counter [16]: 0000,0001,...,1111 (led = step).
  - 1 knight rider [6]: 0001,0010,0100,1000,0100,0010.
  - 2 fill and empty [8]: 0001,0011,0111,1111,0111,0011,0001,0000.
  - 3 alternating pairs [8]: 0011,1100 repeated 4 times.
  - 4 all blink [8]: 1111,0000 repeated 4 times.
- On tick:
  - If step < LEN(pattern_state)-1, step increments.
  - Otherwise step returns to 0 and pattern_state advances (0->1->2->3->4->0).
- Full cycle = 46 ticks = 46*DIV clocks. Sequence continues indefinitely.
- led is a registered output. It is loaded on the same edge as pattern_state/step with the decode of their next values. Hence led always equals PATTERN(pattern_state, step), with no extra latency and no glitches.
- No state changes between ticks.
- Reset (rst=1 at a rising edge), also applies mid-sequence:
  - prescaler = 0, step = 0, pattern_state = 0, led = 0000 on that edge.
  - Held while rst stays high.
  - First tick occurs DIV cycles after the first edge with rst=0.
- Illegal pattern_state (5..7), unreachable: decode to led = 0000 and next state 0.

Test Plan:
- Reset: hold rst=1 for 10 cycles with CLK_FREQ=8, BLINK_FREQ=1 (DIV=8) -> led=0000, pattern_state=0. Release -> led becomes 0001 exactly 8 clocks later, and changes only every 8 clocks.
- Binary counter (DIV=8): over 16 ticks -> led = 0000..1111 in order. The 16th tick gives pattern_state=1, led=0001.
- Knight rider/fill: continue -> 0001,0010,0100,1000,0100,0010, then pattern_state=2 with 0001,0011,0111,1111,0111,0011,0001,0000.
- Pairs/blink/wrap: continue -> 0011/1100 x4, then 1111/0000 x4. The 46th tick returns pattern_state=0, led=0000.
- Mid-run reset: assert rst during pattern 3 -> next edge led=0000, pattern_state=0, step=0. Sequence restarts from the binary counter.
- Default-like rate: CLK_FREQ=50_000_000, BLINK_FREQ=2000 (DIV=25000) -> first led change at 25000 clocks after reset release; exactly 4 changes in 100000 clocks (0001,0010,0011,0100).
